// File: rtl/asi_pkg.sv
// Shared definitions for the user-side slave endpoint: grant states, AXI burst
// codes and the byte-to-word address helper.
package asi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WGNT = 2'd1,
    RGNT = 2'd2
  } gnt_state_t;

  localparam logic [1:0] BT_FIXED    = 2'b00;
  localparam logic [1:0] BT_INCR     = 2'b01;
  localparam logic [1:0] BT_WRAP     = 2'b10;
  localparam logic [1:0] BT_RESERVED = 2'b11;

  // Number of low address bits that select a byte within one memory word.
  function automatic int unsigned word_shift(input int unsigned strbw);
    return $clog2(strbw);
  endfunction

endpackage

// File: rtl/asi_spram_be.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// The read register only loads on a read so it holds the last word otherwise.
module asi_spram_be #(
  parameter int unsigned DW = 128,
  parameter int unsigned AW = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     addr,
  input  logic [DW/8-1:0]   be,
  input  logic [DW-1:0]     wdata,
  input  logic              rd,
  output logic [DW-1:0]     q
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < DW/8; b++) begin
      if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (rd) q <= mem[addr];
  end

endmodule

// File: rtl/asi_usr_mem.sv
// User-side slave endpoint: write/read burst arbiter, byte-strobed word memory
// and a fixed-latency read-return pipeline.
module asi_usr_mem
  import asi_pkg::*;
#(
  parameter int unsigned AXI_DW      = 128,
  parameter int unsigned AXI_AW      = 32,
  parameter int unsigned AXI_SW      = 3,
  parameter int unsigned AXI_WSTRBW  = AXI_DW/8,
  parameter int unsigned ASI_ARB     = 0,
  parameter int unsigned SLV_WS      = 1,
  parameter int unsigned MEM_AW      = 10,
  parameter int unsigned SLV_MAXSIZE = $clog2(AXI_DW/8)
) (
  input  logic                  usr_clk,
  input  logic                  usr_reset,
  input  logic                  usr_wrequest,
  output logic                  usr_wgrant,
  input  logic [AXI_AW-1:0]     usr_waddr,
  input  logic [AXI_DW-1:0]     usr_wdata,
  input  logic [AXI_WSTRBW-1:0] usr_wstrb,
  input  logic                  usr_wlast,
  input  logic                  usr_we,
  input  logic [AXI_SW-1:0]     usr_wsize,
  output logic                  usr_wsize_error,
  input  logic                  usr_rrequest,
  output logic                  usr_rgrant,
  input  logic [AXI_AW-1:0]     usr_raddr,
  input  logic                  usr_re,
  input  logic                  usr_rlast,
  input  logic [AXI_SW-1:0]     usr_rsize,
  output logic                  usr_rsize_error,
  output logic [AXI_DW-1:0]     usr_rdata,
  output logic                  usr_rvalid,
  output logic                  proto_err
);

  localparam int unsigned BSH = word_shift(AXI_WSTRBW);

  gnt_state_t state, state_nxt;

  logic                  wr_fire, rd_fire;
  logic [MEM_AW-1:0]     widx, ridx, ram_addr;
  logic [AXI_WSTRBW-1:0] ram_be;
  logic [AXI_DW-1:0]     ram_q;
  logic [SLV_WS-1:0]     vpipe;
  logic                  unused_addr_hi;

  // Address bits above the memory window alias onto the same words.
  assign widx           = usr_waddr[BSH +: MEM_AW];
  assign ridx           = usr_raddr[BSH +: MEM_AW];
  assign unused_addr_hi = ^{usr_waddr, usr_raddr};

  always_ff @(posedge usr_clk) begin
    if (usr_reset) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (usr_wrequest && usr_rrequest) state_nxt = (ASI_ARB == 0) ? WGNT : RGNT;
        else if (usr_wrequest)            state_nxt = WGNT;
        else if (usr_rrequest)            state_nxt = RGNT;
      end
      WGNT:    if (usr_we && usr_wlast) state_nxt = IDLE;
      RGNT:    if (usr_re && usr_rlast) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    usr_wgrant = (state == WGNT);
    usr_rgrant = (state == RGNT);
  end

  assign wr_fire = usr_we && (state == WGNT) && !usr_reset;
  assign rd_fire = usr_re && (state == RGNT) && !usr_reset;

  always_ff @(posedge usr_clk) begin
    if (usr_reset) proto_err <= 1'b0;
    else if ((usr_we && state != WGNT) || (usr_re && state != RGNT)) proto_err <= 1'b1;
  end

  assign usr_wsize_error = usr_wsize > AXI_SW'(SLV_MAXSIZE);
  assign usr_rsize_error = usr_rsize > AXI_SW'(SLV_MAXSIZE);

  assign ram_addr = (state == WGNT) ? widx : ridx;
  assign ram_be   = wr_fire ? usr_wstrb : '0;

  asi_spram_be #(
    .DW (AXI_DW),
    .AW (MEM_AW)
  ) u_ram (
    .clk   (usr_clk),
    .rst   (usr_reset),
    .addr  (ram_addr),
    .be    (ram_be),
    .wdata (usr_wdata),
    .rd    (rd_fire),
    .q     (ram_q)
  );

  always_ff @(posedge usr_clk) begin
    if (usr_reset) vpipe <= '0;
    else           vpipe <= (vpipe << 1) | SLV_WS'(rd_fire);
  end

  assign usr_rvalid = vpipe[SLV_WS-1];

  // The RAM output register is the first latency stage; extra wait states
  // add data stages that advance only alongside their valid bit, so the
  // last stage holds its word while usr_rvalid is low.
  if (SLV_WS == 1) begin : g_direct
    assign usr_rdata = ram_q;
  end else begin : g_dly
    logic [AXI_DW-1:0] dly [SLV_WS-1];

    always_ff @(posedge usr_clk) begin
      if (usr_reset) begin
        for (int unsigned k = 0; k < SLV_WS-1; k++) dly[k] <= '0;
      end else begin
        if (vpipe[0]) dly[0] <= ram_q;
        for (int unsigned k = 1; k < SLV_WS-1; k++) begin
          if (vpipe[k]) dly[k] <= dly[k-1];
        end
      end
    end

    assign usr_rdata = dly[SLV_WS-2];
  end

endmodule

// File: tb/tb_asi_usr_mem.sv
// Directed bench: one endpoint with defaults (write priority, 1 wait state) and
// one with read priority and 3 wait states, sharing clock and reset.
module tb_asi_usr_mem;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int unsigned passes = 0;
  int unsigned total  = 0;

  // Instance a: ASI_ARB=0, SLV_WS=1
  logic         wreq, wgnt, wlast, we, wsz_err, rreq, rgnt, re, rlast, rsz_err, rvalid, perr;
  logic [31:0]  waddr, raddr;
  logic [127:0] wdata, rdata;
  logic [15:0]  wstrb;
  logic [2:0]   wsize, rsize;

  // Instance b: ASI_ARB=1, SLV_WS=3
  logic         wreq2, wgnt2, wlast2, we2, wsz_err2, rreq2, rgnt2, re2, rlast2, rsz_err2, rvalid2, perr2;
  logic [31:0]  waddr2, raddr2;
  logic [127:0] wdata2, rdata2;
  logic [15:0]  wstrb2;
  logic [2:0]   wsize2, rsize2;

  asi_usr_mem dut_a (
    .usr_clk(clk), .usr_reset(rst),
    .usr_wrequest(wreq), .usr_wgrant(wgnt), .usr_waddr(waddr), .usr_wdata(wdata),
    .usr_wstrb(wstrb), .usr_wlast(wlast), .usr_we(we), .usr_wsize(wsize),
    .usr_wsize_error(wsz_err), .usr_rrequest(rreq), .usr_rgrant(rgnt),
    .usr_raddr(raddr), .usr_re(re), .usr_rlast(rlast), .usr_rsize(rsize),
    .usr_rsize_error(rsz_err), .usr_rdata(rdata), .usr_rvalid(rvalid),
    .proto_err(perr)
  );

  asi_usr_mem #(.ASI_ARB(1), .SLV_WS(3)) dut_b (
    .usr_clk(clk), .usr_reset(rst),
    .usr_wrequest(wreq2), .usr_wgrant(wgnt2), .usr_waddr(waddr2), .usr_wdata(wdata2),
    .usr_wstrb(wstrb2), .usr_wlast(wlast2), .usr_we(we2), .usr_wsize(wsize2),
    .usr_wsize_error(wsz_err2), .usr_rrequest(rreq2), .usr_rgrant(rgnt2),
    .usr_raddr(raddr2), .usr_re(re2), .usr_rlast(rlast2), .usr_rsize(rsize2),
    .usr_rsize_error(rsz_err2), .usr_rdata(rdata2), .usr_rvalid(rvalid2),
    .proto_err(perr2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic wr1(input logic [31:0] a, input logic [127:0] d, input logic [15:0] s);
    wreq = 1'b1;
    tick();
    chk("wr_grant_on", wgnt, 1);
    wreq = 1'b0; we = 1'b1; waddr = a; wdata = d; wstrb = s; wlast = 1'b1;
    tick();
    chk("wr_grant_off", wgnt, 0);
    we = 1'b0; wlast = 1'b0;
    tick();
  endtask

  task automatic rd1(input logic [31:0] a, input logic [127:0] exp);
    rreq = 1'b1;
    tick();
    chk("rd_grant_on", rgnt, 1);
    rreq = 1'b0; re = 1'b1; raddr = a; rlast = 1'b1;
    tick();
    chk("rd_valid", rvalid, 1);
    chk("rd_data", rdata, exp);
    chk("rd_grant_off", rgnt, 0);
    re = 1'b0; rlast = 1'b0;
    tick();
    chk("rd_valid_pulse", rvalid, 0);
    chk("rd_data_hold", rdata, exp);
  endtask

  initial begin
    rst = 1'b1;
    {wreq, wlast, we, rreq, re, rlast} = '0;
    {wreq2, wlast2, we2, rreq2, re2, rlast2} = '0;
    waddr = '0; raddr = '0; wdata = '0; wstrb = '0; wsize = 3'd4; rsize = 3'd4;
    waddr2 = '0; raddr2 = '0; wdata2 = '0; wstrb2 = '0; wsize2 = 3'd4; rsize2 = 3'd4;
    tick();
    tick();
    chk("rst_wgnt", wgnt, 0);
    chk("rst_rgnt", rgnt, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, '0);
    chk("rst_perr", perr, 0);
    chk("rst_rdata_b", rdata2, '0);
    chk("rst_rvalid_b", rvalid2, 0);
    rst = 1'b0;
    tick();

    // Write-then-read
    wr1(32'h40, {16{8'hA5}}, 16'hFFFF);
    rd1(32'h40, {16{8'hA5}});

    // Byte strobes
    wr1(32'h80, '0, 16'hFFFF);
    wr1(32'h80, '1, 16'h000F);
    rd1(32'h80, {96'h0, 32'hFFFF_FFFF});

    // Simultaneous requests, write priority, 4-beat write then 4-beat read
    wreq = 1'b1; rreq = 1'b1;
    tick();
    chk("arb_a_wgnt", wgnt, 1);
    chk("arb_a_rgnt", rgnt, 0);
    wreq = 1'b0;
    for (int i = 0; i < 4; i++) begin
      we = 1'b1; waddr = 32'(i * 16); wdata = {4{32'hC0DE_0000 | 32'(i)}}; wstrb = '1;
      wlast = (i == 3);
      tick();
      chk("arb_a_wgnt_beat", wgnt, (i == 3) ? 0 : 1);
      chk("arb_a_rgnt_beat", rgnt, 0);
    end
    we = 1'b0; wlast = 1'b0;
    tick();
    chk("arb_a_rgnt_after_bubble", rgnt, 1);
    rreq = 1'b0;
    for (int i = 0; i < 4; i++) begin
      re = 1'b1; raddr = 32'(i * 16); rlast = (i == 3);
      tick();
      chk("b2b_a_rvalid", rvalid, 1);
      chk("b2b_a_rdata", rdata, {4{32'hC0DE_0000 | 32'(i)}});
    end
    chk("b2b_a_rgnt_off", rgnt, 0);
    re = 1'b0; rlast = 1'b0;
    tick();
    chk("b2b_a_rvalid_end", rvalid, 0);

    // Aliasing: address bit above the memory window is ignored
    rd1(32'h0001_0040, {16{8'hA5}});

    // Protocol error: write strobe in IDLE
    we = 1'b1; waddr = 32'h40; wdata = '0; wstrb = '1; wlast = 1'b1;
    tick();
    chk("perr_set", perr, 1);
    chk("perr_no_grant", wgnt, 0);
    we = 1'b0; wlast = 1'b0;
    tick();
    chk("perr_held", perr, 1);
    rd1(32'h40, {16{8'hA5}});
    chk("perr_held_after_rd", perr, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("perr_cleared", perr, 0);
    chk("perr_rst_wgnt", wgnt, 0);
    chk("perr_rst_rgnt", rgnt, 0);
    chk("perr_rst_rdata", rdata, '0);

    // Size errors are combinational
    wsize = 3'd5; #1;
    chk("wsize_err_5", wsz_err, 1);
    wsize = 3'd4; #1;
    chk("wsize_err_4", wsz_err, 0);
    rsize = 3'd7; #1;
    chk("rsize_err_7", rsz_err, 1);
    rsize = 3'd0; #1;
    chk("rsize_err_0", rsz_err, 0);
    wsize2 = 3'd6; #1;
    chk("wsize_err_b", wsz_err2, 1);
    wsize2 = 3'd4;
    tick();

    // Instance b: read priority on simultaneous requests
    wreq2 = 1'b1; rreq2 = 1'b1;
    tick();
    chk("arb_b_rgnt", rgnt2, 1);
    chk("arb_b_wgnt", wgnt2, 0);
    rreq2 = 1'b0; re2 = 1'b1; raddr2 = 32'h0; rlast2 = 1'b1;
    tick();
    chk("arb_b_bubble_rgnt", rgnt2, 0);
    chk("arb_b_bubble_wgnt", wgnt2, 0);
    re2 = 1'b0; rlast2 = 1'b0;
    tick();
    chk("arb_b_wgnt_after", wgnt2, 1);
    chk("arb_b_rvalid_early", rvalid2, 0);
    wreq2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      we2 = 1'b1; waddr2 = 32'(i * 16); wdata2 = {4{32'hBEEF_0000 | 32'(i)}}; wstrb2 = '1;
      wlast2 = (i == 3);
      tick();
      if (i == 0) chk("lat_b_single_rvalid", rvalid2, 1);
      if (i == 1) chk("lat_b_single_pulse", rvalid2, 0);
    end
    chk("arb_b_wgnt_off", wgnt2, 0);
    we2 = 1'b0; wlast2 = 1'b0;
    tick();

    // Instance b: latency sweep, 4 back-to-back reads with 3 wait states
    rreq2 = 1'b1;
    tick();
    chk("lat_b_rgnt", rgnt2, 1);
    rreq2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      re2 = 1'b1; raddr2 = 32'(i * 16); rlast2 = (i == 3);
      tick();
      if (i < 2) chk("lat_b_rvalid_wait", rvalid2, 0);
      else begin
        chk("lat_b_rvalid", rvalid2, 1);
        chk("lat_b_rdata", rdata2, {4{32'hBEEF_0000 | 32'(i - 2)}});
      end
    end
    re2 = 1'b0; rlast2 = 1'b0;
    for (int i = 2; i < 4; i++) begin
      tick();
      chk("lat_b_rvalid_tail", rvalid2, 1);
      chk("lat_b_rdata_tail", rdata2, {4{32'hBEEF_0000 | 32'(i)}});
    end
    tick();
    chk("lat_b_rvalid_end", rvalid2, 0);
    chk("lat_b_rdata_hold", rdata2, {4{32'hBEEF_0000 | 32'd3}});
    chk("lat_b_perr", perr2, 0);

    // Instance b: reset during a read burst with a read in flight
    rreq2 = 1'b1;
    tick();
    chk("mid_rst_rgnt", rgnt2, 1);
    rreq2 = 1'b0; re2 = 1'b1; raddr2 = 32'h10; rlast2 = 1'b0;
    tick();
    re2 = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_rgnt_off", rgnt2, 0);
    chk("mid_rst_rvalid", rvalid2, 0);
    chk("mid_rst_rdata", rdata2, '0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mid_rst_no_rvalid", rvalid2, 0);
      chk("mid_rst_idle", rgnt2, 0);
    end

    // Instance a: reset asserted in the same cycle as a read beat
    rreq = 1'b1;
    tick();
    chk("same_rst_rgnt", rgnt, 1);
    rreq = 1'b0; re = 1'b1; raddr = 32'h40; rlast = 1'b0; rst = 1'b1;
    tick();
    re = 1'b0; rst = 1'b0;
    chk("same_rst_rvalid", rvalid, 0);
    chk("same_rst_rgnt_off", rgnt, 0);
    tick();
    chk("same_rst_rvalid_next", rvalid, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
